// File: rtl/ras_ctrl_if.sv
// Fetch/RAS-facing bundle for the return-address-stack controller.
// Signal names mirror the controller's documented pin list.
interface ras_ctrl_if #(
    parameter int STACK_DEPTH = 8,
    parameter int ENTRY_SIZE  = 64,
    parameter int CKPT_DEPTH  = 8
);
    localparam int TW = $clog2(STACK_DEPTH);
    localparam int GW = $clog2(CKPT_DEPTH);

    logic                  fetch_valid_in;
    logic                  fetch_ready_out;
    logic [ENTRY_SIZE-1:0] fetch_pc_in;
    logic [31:0]           fetch_insn_in;
    logic                  fetch_branch_in;
    logic                  ckpt_valid_out;
    logic [GW-1:0]         ckpt_tag_out;
    logic                  pred_valid_out;
    logic [ENTRY_SIZE-1:0] pred_target_out;
    logic                  commit_in;
    logic                  mispredict_in;
    logic [GW-1:0]         mispredict_tag_in;
    logic                  ras_push_out;
    logic                  ras_pop_out;
    logic [ENTRY_SIZE-1:0] ras_pushee_out;
    logic                  ras_restore_out;
    logic [TW-1:0]         ras_new_tail_out;
    logic [ENTRY_SIZE-1:0] ras_top_in;

    modport slave (
        input  fetch_valid_in, fetch_pc_in, fetch_insn_in,
        input  fetch_branch_in, commit_in, mispredict_in,
        input  mispredict_tag_in, ras_top_in,
        output fetch_ready_out, ckpt_valid_out, ckpt_tag_out,
        output pred_valid_out, pred_target_out, ras_push_out,
        output ras_pop_out, ras_pushee_out, ras_restore_out,
        output ras_new_tail_out
    );

    modport master (
        output fetch_valid_in, fetch_pc_in, fetch_insn_in,
        output fetch_branch_in, commit_in, mispredict_in,
        output mispredict_tag_in, ras_top_in,
        input  fetch_ready_out, ckpt_valid_out, ckpt_tag_out,
        input  pred_valid_out, pred_target_out, ras_push_out,
        input  ras_pop_out, ras_pushee_out, ras_restore_out,
        input  ras_new_tail_out
    );
endinterface

// File: rtl/ras_ctrl.sv
// Fetch-side RAS controller: call/ret decode, RET prediction, tail checkpoints.
// STACK_DEPTH and CKPT_DEPTH are powers of two so pointers wrap naturally.
module ras_ctrl #(
    parameter int STACK_DEPTH = 8,
    parameter int ENTRY_SIZE  = 64,
    parameter int CKPT_DEPTH  = 8
) (
    input logic       clk_in,
    input logic       rst_in,
    ras_ctrl_if.slave bus
);
    localparam int TW = $clog2(STACK_DEPTH);
    localparam int GW = $clog2(CKPT_DEPTH);
    localparam logic [TW:0] SMAX = (TW+1)'(STACK_DEPTH);
    localparam logic [GW:0] CMAX = (GW+1)'(CKPT_DEPTH);
    localparam logic [GW:0] CONE = (GW+1)'(1);

    logic [TW-1:0]         tail, n_tail;
    logic [TW:0]           size, n_size;
    logic [GW-1:0]         head, wptr, diff;
    logic [GW:0]           count, n_count;
    logic [TW-1:0]         ck_tail [CKPT_DEPTH];
    logic [TW:0]           ck_size [CKPT_DEPTH];
    logic                  is_call, is_ret, needs, ready, acc;
    logic                  alloc, cmt, push, pop, mis;
    logic                  ckpt_valid_q, pred_valid_q;
    logic [GW-1:0]         ckpt_tag_q;
    logic [ENTRY_SIZE-1:0] pred_target_q;

    always_comb begin
        is_call = ((bus.fetch_insn_in & 32'hFC00_0000) == 32'h9400_0000)
               || ((bus.fetch_insn_in & 32'hFFFF_FC1F) == 32'hD63F_0000);
        is_ret  = (bus.fetch_insn_in & 32'hFFFF_FC1F) == 32'hD65F_0000;
        needs   = is_call || is_ret || bus.fetch_branch_in;
        mis     = bus.mispredict_in;
        ready   = !mis && !(needs && count == CMAX);
        acc     = bus.fetch_valid_in && ready;
        alloc   = acc && needs;
        cmt     = bus.commit_in && (count != '0);
    end

    // A full stack keeps size pinned; the new push overwrites the oldest slot.
    always_comb begin
        n_tail = tail;
        n_size = size;
        push   = 1'b0;
        pop    = 1'b0;
        if (acc && is_call) begin
            push   = 1'b1;
            n_tail = tail + 1'b1;
            if (size != SMAX)
                n_size = size + 1'b1;
        end else if (acc && is_ret && size != '0) begin
            pop    = 1'b1;
            n_tail = tail - 1'b1;
            n_size = size - 1'b1;
        end
    end

    always_comb begin
        diff = bus.mispredict_tag_in - head;
        if (mis)
            n_count = {1'b0, diff} + CONE - (GW+1)'(cmt);
        else
            n_count = count + (GW+1)'(alloc) - (GW+1)'(cmt);
    end

    always_ff @(posedge clk_in) begin
        if (alloc) begin
            ck_tail[wptr] <= n_tail;
            ck_size[wptr] <= n_size;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tail          <= '0;
            size          <= '0;
            head          <= '0;
            wptr          <= '0;
            count         <= '0;
            ckpt_valid_q  <= 1'b0;
            ckpt_tag_q    <= '0;
            pred_valid_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            ckpt_valid_q <= alloc;
            pred_valid_q <= pop;
            count        <= n_count;
            head         <= head + GW'(cmt);
            if (alloc)
                ckpt_tag_q <= wptr;
            if (pop)
                pred_target_q <= bus.ras_top_in;
            if (mis) begin
                tail <= ck_tail[bus.mispredict_tag_in];
                size <= ck_size[bus.mispredict_tag_in];
                wptr <= bus.mispredict_tag_in + 1'b1;
            end else begin
                tail <= n_tail;
                size <= n_size;
                if (alloc)
                    wptr <= wptr + 1'b1;
            end
        end
    end

    assign bus.fetch_ready_out  = ready;
    assign bus.ckpt_valid_out   = ckpt_valid_q;
    assign bus.ckpt_tag_out     = ckpt_tag_q;
    assign bus.pred_valid_out   = pred_valid_q;
    assign bus.pred_target_out  = pred_target_q;
    assign bus.ras_push_out     = push && !rst_in;
    assign bus.ras_pop_out      = pop && !rst_in;
    assign bus.ras_pushee_out   = (push && !rst_in)
                                ? bus.fetch_pc_in + ENTRY_SIZE'(4) : '0;
    assign bus.ras_restore_out  = mis && !rst_in;
    assign bus.ras_new_tail_out = (mis && !rst_in)
                                ? ck_tail[bus.mispredict_tag_in] : '0;
endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed scenarios plus random traffic against a
// queue-based model of the stack and checkpoint list.
module tb_ras_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    ras_ctrl_if #(.STACK_DEPTH(8), .ENTRY_SIZE(64), .CKPT_DEPTH(8)) bus ();

    ras_ctrl #(.STACK_DEPTH(8), .ENTRY_SIZE(64), .CKPT_DEPTH(8)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    localparam logic [31:0] NOP = 32'hD503201F;
    localparam logic [31:0] RET = 32'hD65F03C0;

    typedef struct { int tag; int tail; int size; } ck_t;

    int n_chk = 0;
    int n_fail = 0;

    // downstream stack as seen by the controller
    logic [63:0] env_stk [8];
    logic [2:0]  env_ptr;
    assign bus.ras_top_in = env_stk[env_ptr - 3'd1];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            env_ptr <= '0;
        else if (bus.ras_restore_out)
            env_ptr <= bus.ras_new_tail_out;
        else if (bus.ras_push_out) begin
            env_stk[env_ptr] <= bus.ras_pushee_out;
            env_ptr <= env_ptr + 3'd1;
        end else if (bus.ras_pop_out)
            env_ptr <= env_ptr - 3'd1;
    end

    // reference model
    int          m_tail, m_size, m_wptr, e_ckt;
    logic [63:0] m_stk [8];
    ck_t         q [$];
    bit          e_ckv, e_pv;
    logic [63:0] e_pt;

    bit          obs_ready, obs_push, obs_pop, obs_restore;
    logic [63:0] obs_pushee;
    logic [2:0]  obs_nt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tail = 0; m_size = 0; m_wptr = 0;
        q.delete();
        e_ckv = 0; e_pv = 0; e_ckt = 0; e_pt = '0;
    endtask

    task automatic step(input bit v, input logic [31:0] insn,
                        input logic [63:0] pc, input bit br, input bit cm,
                        input bit mis, input int mt);
        bit call, ret, needs, rdy, acc;
        int k;
        @(negedge clk_in);
        bus.fetch_valid_in    = v;
        bus.fetch_insn_in     = insn;
        bus.fetch_pc_in       = pc;
        bus.fetch_branch_in   = br;
        bus.commit_in         = cm;
        bus.mispredict_in     = mis;
        bus.mispredict_tag_in = 3'(mt);
        #1;
        call  = insn[31:26] == 6'b100101 ||
                (insn[31:10] == 22'h358FC0 && insn[4:0] == 5'd0);
        ret   = insn[31:10] == 22'h3597C0 && insn[4:0] == 5'd0;
        needs = call || ret || br;
        rdy   = !mis && !(needs && q.size() == 8);
        acc   = v && rdy;
        k = -1;
        foreach (q[i]) if (q[i].tag == mt) k = i;

        chk("ready", bus.fetch_ready_out, rdy);
        chk("push", bus.ras_push_out, acc && call);
        if (acc && call) chk("pushee", bus.ras_pushee_out, pc + 64'd4);
        chk("pop", bus.ras_pop_out, acc && ret && m_size > 0);
        chk("restore", bus.ras_restore_out, mis);
        if (mis && k >= 0)
            chk("new_tail", bus.ras_new_tail_out, q[k].tail);
        chk("ckpt_valid", bus.ckpt_valid_out, e_ckv);
        if (e_ckv) chk("ckpt_tag", bus.ckpt_tag_out, e_ckt);
        chk("pred_valid", bus.pred_valid_out, e_pv);
        if (e_pv) chk("pred_target", bus.pred_target_out, e_pt);

        obs_ready   = bus.fetch_ready_out;
        obs_push    = bus.ras_push_out;
        obs_pop     = bus.ras_pop_out;
        obs_restore = bus.ras_restore_out;
        obs_pushee  = bus.ras_pushee_out;
        obs_nt      = bus.ras_new_tail_out;

        e_ckv = 0; e_pv = 0;
        if (mis) begin
            if (k >= 0) begin
                m_tail = q[k].tail;
                m_size = q[k].size;
                while (q.size() > k + 1) void'(q.pop_back());
            end
            m_wptr = (mt + 1) % 8;
            if (cm && q.size() > 0) void'(q.pop_front());
        end else begin
            if (cm && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                if (call) begin
                    m_stk[m_tail] = pc + 64'd4;
                    m_tail = (m_tail + 1) % 8;
                    if (m_size < 8) m_size++;
                end else if (ret && m_size > 0) begin
                    m_tail = (m_tail + 7) % 8;
                    m_size--;
                    e_pv = 1;
                    e_pt = m_stk[m_tail];
                end
                if (needs) begin
                    q.push_back('{m_wptr, m_tail, m_size});
                    e_ckv = 1;
                    e_ckt = m_wptr;
                    m_wptr = (m_wptr + 1) % 8;
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        bus.fetch_valid_in = 1'b1;
        bus.fetch_insn_in  = 32'h94000001;
        bus.fetch_pc_in    = 64'h40;
        bus.commit_in      = 1'b1;
        bus.mispredict_in  = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("rst_push", bus.ras_push_out, 0);
        chk("rst_pushee", bus.ras_pushee_out, 0);
        chk("rst_pop", bus.ras_pop_out, 0);
        chk("rst_ckpt_valid", bus.ckpt_valid_out, 0);
        chk("rst_pred_valid", bus.pred_valid_out, 0);
        chk("rst_restore", bus.ras_restore_out, 0);
        chk("rst_ready", bus.fetch_ready_out, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        bus.fetch_valid_in = 1'b0;
        bus.commit_in      = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        logic [4:0]  rn;
        rn = 5'($urandom);
        case ($urandom_range(0, 5))
            0:       w = {6'b100101, 26'($urandom)};
            1:       w = 32'hD63F0000 | {22'd0, rn, 5'd0};
            2, 3:    w = 32'hD65F0000 | {22'd0, rn, 5'd0};
            4:       w = 32'hD65F03C1;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fetch_valid_in    = 1'b0;
        bus.fetch_insn_in     = NOP;
        bus.fetch_pc_in       = '0;
        bus.fetch_branch_in   = 1'b0;
        bus.commit_in         = 1'b0;
        bus.mispredict_in     = 1'b0;
        bus.mispredict_tag_in = '0;
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // reset mid-stream with three live checkpoints
        for (int i = 0; i < 3; i++)
            step(1, 32'h94000010, 64'h100 * (i + 1), 0, 0, 0, 0);
        do_reset();
        step(1, 32'h94000010, 64'h500, 0, 0, 0, 0);
        chk("t1_ckpt_valid", bus.ckpt_valid_out, 1);
        chk("t1_tag", bus.ckpt_tag_out, 0);

        // BL then RET
        do_reset();
        step(1, 32'h94000010, 64'h1000, 0, 0, 0, 0);
        chk("t2_push", obs_push, 1);
        chk("t2_pushee", obs_pushee, 64'h1004);
        chk("t2_tag", bus.ckpt_tag_out, 0);
        step(1, RET, 64'h2000, 0, 0, 0, 0);
        chk("t2_pop", obs_pop, 1);
        chk("t2_pred_valid", bus.pred_valid_out, 1);
        chk("t2_target", bus.pred_target_out, 64'h1004);

        // RET on empty stack
        do_reset();
        step(1, RET, 64'h3000, 0, 0, 0, 0);
        chk("t3_pop", obs_pop, 0);
        chk("t3_pred_valid", bus.pred_valid_out, 0);
        chk("t3_ckpt_valid", bus.ckpt_valid_out, 1);

        // checkpoint queue full
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1, NOP, 64'h4000 + 64'(4 * i), 1, 0, 0, 0);
        step(1, NOP, 64'h4100, 1, 0, 0, 0);
        chk("t4_full_ready", obs_ready, 0);
        step(1, NOP, 64'h4100, 1, 1, 0, 0);
        chk("t4_commit_ready", obs_ready, 0);
        step(1, NOP, 64'h4100, 1, 0, 0, 0);
        chk("t4_after_ready", obs_ready, 1);
        chk("t4_tag", bus.ckpt_tag_out, 0);

        // mispredict rewind
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1, 32'h94000010, 64'h100 * (i + 1), 0, 0, 0, 0);
        step(0, NOP, 0, 0, 0, 1, 0);
        chk("t5_restore", obs_restore, 1);
        chk("t5_new_tail", obs_nt, 1);
        chk("t5_push", obs_push, 0);
        step(1, 32'h94000010, 64'h400, 0, 0, 0, 0);
        chk("t5_tag", bus.ckpt_tag_out, 1);
        chk("t5_stack1", env_stk[1], 64'h404);

        // overflow then drain
        do_reset();
        for (int k = 1; k <= 9; k++)
            step(1, 32'h94000010, 64'h1000 * k, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, RET, 64'h20000, 0, 1, 0, 0);
            chk("t6_pred_valid", bus.pred_valid_out, 1);
            chk("t6_target", bus.pred_target_out,
                64'h1000 * (9 - i) + 64'h4);
        end
        step(1, RET, 64'h20000, 0, 1, 0, 0);
        chk("t6_last_pred_valid", bus.pred_valid_out, 0);

        // pushee wraps
        step(1, 32'h94000010, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
        chk("wrap_pushee", obs_pushee, 64'h0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          v, br, cm, mis;
            int          mt;
            logic [63:0] pc;
            if (i == 1500) do_reset();
            v   = $urandom_range(0, 9) < 8;
            br  = $urandom_range(0, 3) == 0;
            cm  = $urandom_range(0, 9) < 4;
            mis = q.size() > 0 && $urandom_range(0, 99) < 8;
            mt  = mis ? q[$urandom_range(0, q.size() - 1)].tag : 0;
            pc  = ($urandom_range(0, 31) == 0)
                ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            step(v, rand_insn(), pc, br, cm, mis, mt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
